// File: rtl/mem_resp_pkg.sv
// Shared definitions for the mem_responder slice: per-port FSM state encoding,
// latency counter width, bus widths and the stall LFSR constants/step function.
// No ports; imported by mem_responder_if, mem_resp_port and mem_responder.
package mem_resp_pkg;

   // Bus widths seen by both requesters.
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   // Latency counter must hold LATENCY-1 (max 14) plus up to 3 stall cycles.
   localparam int unsigned CNT_W = 5;

   // Per-port FSM state encoding (kept as plain constants for older tools).
   typedef logic [1:0] port_state_t;
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAIT    = 2'd1;
   localparam logic [1:0] ST_RESP    = 2'd2;
   localparam logic [1:0] ST_RECOVER = 2'd3;

   // Stall generator: 8-bit Galois LFSR.
   localparam logic [7:0] LFSR_SEED = 8'h5A;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   // One Galois step: shift right, fold the taps in when a 1 falls out.
   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      logic [7:0] s;
      s = v >> 1;
      if (v[0]) begin
         s = s ^ LFSR_TAPS;
      end
      return s;
   endfunction

endpackage : mem_resp_pkg

// File: rtl/mem_responder_if.sv
// Request/response bundle between a two-port requester (instruction + data)
// and the memory responder. master = requester side, slave = responder side.
// Signals: inst_read/inst_addr -> inst_rdata/inst_resp; data_read/data_write/
// data_addr/data_wdata -> data_rdata/data_resp. Requests are held until resp.
interface mem_responder_if;
   import mem_resp_pkg::*;

   logic              inst_read;
   logic [ADDR_W-1:0] inst_addr;
   logic [DATA_W-1:0] inst_rdata;
   logic              inst_resp;

   logic              data_read;
   logic              data_write;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wdata;
   logic [DATA_W-1:0] data_rdata;
   logic              data_resp;

   modport master (
      output inst_read, inst_addr,
      output data_read, data_write, data_addr, data_wdata,
      input  inst_rdata, inst_resp,
      input  data_rdata, data_resp
   );

   modport slave (
      input  inst_read, inst_addr,
      input  data_read, data_write, data_addr, data_wdata,
      output inst_rdata, inst_resp,
      output data_rdata, data_resp
   );

endinterface : mem_responder_if

// File: rtl/mem_resp_port.sv
// One request port's sequencing: IDLE -> WAIT -> RESP -> RECOVER -> IDLE.
// Latency: request sampled in IDLE at cycle t gives resp_o at t+LATENCY
// (plus 0..3 stall cycles when MEM_RESP_LFSR_STALL_EN is defined).
// Backpressure: none; a request dropped in WAIT aborts back to IDLE.
// Ports: clk, rst_n (sync, active-low), req_i (held request), resp_o (1-cycle).
module mem_resp_port
   import mem_resp_pkg::*;
#(
   parameter int unsigned LATENCY = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_i,
   output logic resp_o
);

   port_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] load_val;
   logic             accept;

`ifdef MEM_RESP_LFSR_STALL_EN
   logic [7:0] lfsr_q, lfsr_d;

   // Stall amount comes from the current LFSR value; the LFSR then steps so
   // the next accepted request sees a fresh value.
   assign load_val = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[1:0]);

   always_comb begin
      lfsr_d = lfsr_q;
      if (accept) begin
         lfsr_d = lfsr_next(lfsr_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   assign load_val = CNT_W'(LATENCY - 1);
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_i) begin
               accept = 1'b1;
               // Nothing left to wait for: respond in the very next cycle.
               if (load_val == '0) begin
                  state_d = ST_RESP;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = load_val;
               end
            end
         end
         ST_WAIT: begin
            if (!req_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q <= CNT_W'(1)) begin
               // Counter decrements to zero on this edge -> respond next cycle.
               state_d = ST_RESP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_RECOVER;
         end
         ST_RECOVER: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign resp_o = (state_q == ST_RESP);

endmodule : mem_resp_port

// File: rtl/mem_responder.sv
// Two-port (instruction read, data read/write) word memory model with a fixed
// request-to-response latency per port; array contents survive reset.
// Latency: LATENCY cycles from request acceptance to the one-cycle resp pulse
// (plus 0..3 stall cycles per request when MEM_RESP_LFSR_STALL_EN is defined).
// Backpressure: none; requests are held by the requester until resp.
// Ports: clk, rst_n (sync, active-low), bus (mem_responder_if.slave).
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int unsigned LATENCY     = 2,
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic           clk,
   input  logic           rst_n,
   mem_responder_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

   logic             inst_resp;
   logic             data_resp;
   logic             data_req;
   logic             data_is_read;
   logic             data_is_write;
   logic [IDX_W-1:0] inst_idx;
   logic [IDX_W-1:0] data_idx;

   // Byte address -> word index; upper bits dropped so addresses wrap.
   assign inst_idx = bus.inst_addr[IDX_W+1:2];
   assign data_idx = bus.data_addr[IDX_W+1:2];

   // Read wins when both are raised; the write is then ignored.
   assign data_req      = bus.data_read | bus.data_write;
   assign data_is_read  = bus.data_read;
   assign data_is_write = bus.data_write & ~bus.data_read;

   mem_resp_port #(.LATENCY(LATENCY)) u_inst_port (
      .clk    (clk),
      .rst_n  (rst_n),
      .req_i  (bus.inst_read),
      .resp_o (inst_resp)
   );

   mem_resp_port #(.LATENCY(LATENCY)) u_data_port (
      .clk    (clk),
      .rst_n  (rst_n),
      .req_i  (data_req),
      .resp_o (data_resp)
   );

   // Commit at the end of the RESP cycle. Reads of the same word in that
   // cycle see the old contents because the array read is combinational.
   always_ff @(posedge clk) begin
      if (rst_n && data_resp && data_is_write) begin
         mem_q[data_idx] <= bus.data_wdata;
      end
   end

   assign bus.inst_resp  = inst_resp;
   assign bus.data_resp  = data_resp;
   assign bus.inst_rdata = inst_resp ? mem_q[inst_idx] : '0;
   assign bus.data_rdata = (data_resp && data_is_read) ? mem_q[data_idx] : '0;

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (LATENCY=2, DEPTH_WORDS=1024): inputs are
// driven and outputs sampled 1 time unit after each rising edge, so "cycle c"
// is the interval following the c-th edge.
module tb_mem_responder;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   mem_responder_if bus();

   mem_responder #(.LATENCY(2), .DEPTH_WORDS(1024)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Full data-port transaction with exact cycle checks (LATENCY=2).
   task automatic data_txn(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp);
      bus.data_read  = rd;
      bus.data_write = wr;
      bus.data_addr  = addr;
      bus.data_wdata = wdata;
      tick;
      chk({tag, "_wait_resp"}, {31'b0, bus.data_resp}, 32'd0);
      chk({tag, "_wait_rdata"}, bus.data_rdata, 32'd0);
      tick;
      chk({tag, "_resp"}, {31'b0, bus.data_resp}, 32'd1);
      chk({tag, "_rdata"}, bus.data_rdata, exp);
      tick;
      chk({tag, "_recover_resp"}, {31'b0, bus.data_resp}, 32'd0);
      chk({tag, "_recover_rdata"}, bus.data_rdata, 32'd0);
      bus.data_read  = 1'b0;
      bus.data_write = 1'b0;
      tick;
   endtask

   task automatic inst_txn(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      bus.inst_read = 1'b1;
      bus.inst_addr = addr;
      tick;
      chk({tag, "_wait_resp"}, {31'b0, bus.inst_resp}, 32'd0);
      chk({tag, "_wait_rdata"}, bus.inst_rdata, 32'd0);
      tick;
      chk({tag, "_resp"}, {31'b0, bus.inst_resp}, 32'd1);
      chk({tag, "_rdata"}, bus.inst_rdata, exp);
      tick;
      chk({tag, "_recover_resp"}, {31'b0, bus.inst_resp}, 32'd0);
      chk({tag, "_recover_rdata"}, bus.inst_rdata, 32'd0);
      bus.inst_read = 1'b0;
      tick;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.inst_read  = 1'b0;
      bus.inst_addr  = '0;
      bus.data_read  = 1'b0;
      bus.data_write = 1'b0;
      bus.data_addr  = '0;
      bus.data_wdata = '0;
      rst_n          = 1'b0;
      repeat (3) tick;

      // Reset state.
      chk("rst_inst_resp", {31'b0, bus.inst_resp}, 32'd0);
      chk("rst_data_resp", {31'b0, bus.data_resp}, 32'd0);
      chk("rst_inst_rdata", bus.inst_rdata, 32'd0);
      chk("rst_data_rdata", bus.data_rdata, 32'd0);
      rst_n = 1'b1;
      tick;

      // Word 4 = 0xDEADBEEF, then instruction read with exact latency.
      data_txn("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'd0);
      inst_txn("ird10", 32'h10, 32'hDEADBEEF);

      // Write then read back through the data port.
      data_txn("wr20", 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 32'd0);
      data_txn("rd20", 1'b1, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D);

      // Read and write together: treated as a read, write discarded.
      data_txn("rdwr20", 1'b1, 1'b1, 32'h20, 32'h11111111, 32'hCAFEF00D);
      data_txn("rd20b", 1'b1, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D);

      // Same-cycle inst read and data write to one word: old value seen.
      data_txn("wr30", 1'b0, 1'b1, 32'h30, 32'hAAAA0001, 32'd0);
      bus.inst_read  = 1'b1;
      bus.inst_addr  = 32'h30;
      bus.data_write = 1'b1;
      bus.data_addr  = 32'h30;
      bus.data_wdata = 32'hBBBB0002;
      tick;
      tick;
      chk("rbw_inst_resp", {31'b0, bus.inst_resp}, 32'd1);
      chk("rbw_data_resp", {31'b0, bus.data_resp}, 32'd1);
      chk("rbw_old_value", bus.inst_rdata, 32'hAAAA0001);
      tick;
      bus.inst_read  = 1'b0;
      bus.data_write = 1'b0;
      tick;
      inst_txn("rbw_new", 32'h30, 32'hBBBB0002);

      // Write dropped in WAIT: no resp, word unchanged.
      bus.data_write = 1'b1;
      bus.data_addr  = 32'h30;
      bus.data_wdata = 32'h12345678;
      tick;
      bus.data_write = 1'b0;
      tick;
      chk("abort_no_resp", {31'b0, bus.data_resp}, 32'd0);
      tick;
      chk("abort_no_resp2", {31'b0, bus.data_resp}, 32'd0);
      data_txn("abort_rd", 1'b1, 1'b0, 32'h30, 32'h0, 32'hBBBB0002);

      // Reset pulse in WAIT with the write still held: cancelled.
      bus.data_write = 1'b1;
      bus.data_addr  = 32'h30;
      bus.data_wdata = 32'h87654321;
      tick;
      rst_n = 1'b0;
      tick;
      chk("rstwait_no_resp", {31'b0, bus.data_resp}, 32'd0);
      bus.data_write = 1'b0;
      rst_n          = 1'b1;
      tick;
      chk("rstwait_no_resp2", {31'b0, bus.data_resp}, 32'd0);
      tick;
      data_txn("rstwait_rd", 1'b1, 1'b0, 32'h30, 32'h0, 32'hBBBB0002);
      // Array survives reset.
      inst_txn("rst_keep10", 32'h10, 32'hDEADBEEF);

      // Address wrap modulo DEPTH_WORDS*4.
      data_txn("wr1004", 1'b0, 1'b1, 32'h1004, 32'h5EED0004, 32'd0);
      data_txn("rd0004", 1'b1, 1'b0, 32'h0004, 32'h0, 32'h5EED0004);

      // Request held through RECOVER: next resp LATENCY+2 = 4 cycles later.
      bus.inst_read = 1'b1;
      bus.inst_addr = 32'h10;
      tick;
      tick;
      chk("hold_first_resp", {31'b0, bus.inst_resp}, 32'd1);
      tick;
      chk("hold_recover", {31'b0, bus.inst_resp}, 32'd0);
      tick;
      chk("hold_idle", {31'b0, bus.inst_resp}, 32'd0);
      tick;
      chk("hold_wait", {31'b0, bus.inst_resp}, 32'd0);
      tick;
      chk("hold_second_resp", {31'b0, bus.inst_resp}, 32'd1);
      chk("hold_second_rdata", bus.inst_rdata, 32'hDEADBEEF);
      tick;
      bus.inst_read = 1'b0;
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_mem_responder

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to resp (legal 1..15).
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, meaning 32-bit words in backing array (power of two).
REQ-003 SHALL have clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have rst_n  input  1  meaning synchronous, active-low reset.
REQ-005 SHALL have inst_read  input  1  meaning instruction read request, held until inst_resp.
REQ-006 SHALL have inst_addr  input  32  meaning instruction byte address.
REQ-007 SHALL have inst_rdata  output  32  meaning instruction word, valid only while inst_resp=1.
REQ-008 SHALL have inst_resp  output  1  meaning one-cycle instruction completion pulse.
REQ-009 SHALL have data_read  input  1  meaning data read request, held until data_resp.
REQ-010 SHALL have data_write  input  1  meaning data write request, held until data_resp.
REQ-011 SHALL have data_addr  input  32  meaning data byte address.
REQ-012 SHALL have data_wdata  input  32  meaning write word.
REQ-013 SHALL have data_rdata  output  32  meaning data read word, valid only while data_resp=1.
REQ-014 SHALL have data_resp  output  1  meaning one-cycle data completion pulse.

Function
REQ-015 Each port SHALL run an independent FSM: IDLE, WAIT, RESP, RECOVER.
REQ-016 IDLE->WAIT when request sampled high; latency counter loads LATENCY-1; with LATENCY=1, IDLE->RESP directly.
REQ-017 WAIT decrements the counter each cycle; WAIT->RESP when counter is 0.
REQ-018 Request sampled in IDLE at cycle t SHALL produce resp high at cycle t+LATENCY, for exactly one cycle.
REQ-019 RESP->RECOVER unconditionally; RECOVER holds resp=0, ignores requests, then ->IDLE.
REQ-020 A request dropping in WAIT SHALL abort to IDLE with no resp and no array write.
REQ-021 data_read and data_write both high SHALL be treated as a read; the write is ignored.
REQ-022 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] and higher bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-023 Data write SHALL commit data_wdata to the array at the end of the data RESP cycle.
REQ-024 Read data SHALL be taken from the array in the RESP cycle; a same-cycle write to the same word is not visible (read-before-write).
REQ-025 rdata outputs SHALL be 0 whenever their resp is 0.
REQ-026 Address and wdata SHALL be re-sampled in RESP; changes during WAIT do not alter the result.

Reset
REQ-027 When rst_n=0 at a clock edge, both FSMs SHALL go to IDLE, counters to 0, and inst_resp, data_resp, inst_rdata and data_rdata to 0.
REQ-028 Reset mid-WAIT SHALL cancel the transaction; no resp and no write occur.
REQ-029 Array contents SHALL NOT be affected by reset.

Configuration
REQ-030 With MEM_RESP_LFSR_STALL_EN defined, each accepted request SHALL add 0..3 extra WAIT cycles, taken from bits [1:0] of a per-port 8-bit Galois LFSR (taps 0xB8, reset seed 0x5A), advanced once per accepted request.
REQ-031 Without MEM_RESP_LFSR_STALL_EN, latency SHALL be exactly LATENCY and no LFSR logic SHALL exist.

Structure
REQ-032 Package mem_resp_pkg SHALL hold the state enum, LFSR seed/tap constants and the counter width.
REQ-033 Sub-module mem_resp_port (FSM, counter, optional LFSR) SHALL be instantiated once per port; the top holds the array and the read/write muxing.

Verification
REQ-034 With LATENCY=2, raise inst_read at addr 0x10 (word 4 = 0xDEADBEEF) in cycle 0 -> inst_resp=1 and inst_rdata=0xDEADBEEF in cycle 2 only.
REQ-035 Write 0xCAFEF00D to 0x20 and hold the request, then read 0x20 -> read returns 0xCAFEF00D; rdata is 0 outside resp.
REQ-036 Issue inst read and data write to the same word so both hit RESP in the same cycle -> inst_rdata returns the old value, and the next read returns the new value.
REQ-037 Drop data_write in WAIT, or pulse rst_n=0 in WAIT -> no data_resp, and the array word is unchanged.
REQ-038 With DEPTH_WORDS=1024, write to 0x1004 -> reading 0x0004 returns the value; holding request through RECOVER -> new resp arrives exactly LATENCY+2 cycles after the prior resp.
